// File: rtl/pipelined_csel_subtractor_pkg.sv
// Shared widths and the stage-1 payload of the
// pipelined carry-select subtractor.
package pipelined_csel_subtractor_pkg;

  localparam int SUB_WIDTH = 16;
  localparam int SUB_BLOCK = 4;
  localparam int SUB_HALF  = SUB_WIDTH / 2;
  localparam int SUB_NUP   = SUB_HALF / SUB_BLOCK;

  // Low half is resolved in stage 1; the upper
  // half travels as both carry-in candidates.
  typedef struct packed {
    logic [SUB_HALF-1:0]               lowDiff;
    logic                              midBorrow;
    logic [SUB_NUP-1:0][SUB_BLOCK-1:0] upSum0;
    logic [SUB_NUP-1:0][SUB_BLOCK-1:0] upSum1;
    logic [SUB_NUP-1:0]                upCout0;
    logic [SUB_NUP-1:0]                upCout1;
    logic                              aMsb;
    logic                              bMsb;
  } s1_t;

endpackage

// File: rtl/pipelined_csel_subtractor_if.sv
// Operand/result bundle with valid/ready on both sides.
// master = producer/consumer side, slave = subtractor.
interface pipelined_csel_subtractor_if
  import pipelined_csel_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
);

  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrowIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] diff;
  logic             borrowOut;
  logic             overflow;
  logic             zero;

  modport master (
    output inValid, a, b, borrowIn, outReady,
    input  inReady, outValid, diff,
    input  borrowOut, overflow, zero
  );

  modport slave (
    input  inValid, a, b, borrowIn, outReady,
    output inReady, outValid, diff,
    output borrowOut, overflow, zero
  );

endinterface

// File: rtl/pipelined_csel_subtractor_sub_block.sv
// BLOCK-bit ripple block: sum = a + ~b + cin.
// Ports: a, b, cin in; sum, cout out (cout = ~borrow).
module sub_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK-1:0] nb;
  logic [BLOCK:0]   c;

  assign nb   = ~b;
  assign c[0] = cin;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    assign sum[i]   = a[i] ^ nb[i] ^ c[i];
    assign c[i+1]   = (a[i] & nb[i])
                    | (c[i] & (a[i] ^ nb[i]));
  end

  assign cout = c[BLOCK];

endmodule

// File: rtl/pipelined_csel_subtractor.sv
// 2-stage carry-select subtractor, diff = a - b - borrowIn.
// Ports: clk, rst (sync, active high), io (slave bundle).
module pipelined_csel_subtractor
  import pipelined_csel_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int BLOCK = SUB_BLOCK
) (
  input  logic clk,
  input  logic rst,
  pipelined_csel_subtractor_if.slave io
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int NLO  = NBLK / 2;
  localparam int NUP  = NBLK - NLO;
  localparam int HALF = WIDTH / 2;

  logic [NBLK-1:0][BLOCK-1:0] sum0;
  logic [NBLK-1:0][BLOCK-1:0] sum1;
  logic [NBLK-1:0]            co0;
  logic [NBLK-1:0]            co1;

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    sub_block #(.BLOCK(BLOCK)) u_c0 (
      .a    (io.a[j*BLOCK +: BLOCK]),
      .b    (io.b[j*BLOCK +: BLOCK]),
      .cin  (1'b0),
      .sum  (sum0[j]),
      .cout (co0[j])
    );
    sub_block #(.BLOCK(BLOCK)) u_c1 (
      .a    (io.a[j*BLOCK +: BLOCK]),
      .b    (io.b[j*BLOCK +: BLOCK]),
      .cin  (1'b1),
      .sum  (sum1[j]),
      .cout (co1[j])
    );
  end

  logic s1Valid;
  logic s2Valid;
  logic s1En;
  logic s2En;

  assign s2En = !s2Valid || io.outReady;
  assign s1En = !s1Valid || s2En;

  s1_t  nxt;
  s1_t  s1q;
  logic lc;

  // Carry = ~borrow; block 0 takes ~borrowIn.
  always_comb begin
    nxt = '0;
    lc  = ~io.borrowIn;
    for (int j = 0; j < NLO; j++) begin
      nxt.lowDiff[j*BLOCK +: BLOCK] =
        lc ? sum1[j] : sum0[j];
      lc = lc ? co1[j] : co0[j];
    end
    nxt.midBorrow = ~lc;
    for (int k = 0; k < NUP; k++) begin
      nxt.upSum0[k]  = sum0[NLO+k];
      nxt.upSum1[k]  = sum1[NLO+k];
      nxt.upCout0[k] = co0[NLO+k];
      nxt.upCout1[k] = co1[NLO+k];
    end
    nxt.aMsb = io.a[WIDTH-1];
    nxt.bMsb = io.b[WIDTH-1];
  end

  logic [WIDTH-1:0] d;
  logic             uc;
  logic             boN;
  logic             ovfN;
  logic             zN;

  always_comb begin
    d            = '0;
    d[HALF-1:0]  = s1q.lowDiff;
    uc           = ~s1q.midBorrow;
    for (int k = 0; k < NUP; k++) begin
      d[HALF+k*BLOCK +: BLOCK] =
        uc ? s1q.upSum1[k] : s1q.upSum0[k];
      uc = uc ? s1q.upCout1[k] : s1q.upCout0[k];
    end
    boN  = ~uc;
    ovfN = (s1q.aMsb ^ s1q.bMsb)
         & (d[WIDTH-1] ^ s1q.aMsb);
    zN   = (d == '0);
  end

  logic [WIDTH-1:0] dq;
  logic             boq;
  logic             ovfq;
  logic             zq;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1q     <= '0;
      s2Valid <= 1'b0;
      dq      <= '0;
      boq     <= 1'b0;
      ovfq    <= 1'b0;
      zq      <= 1'b0;
    end else begin
      if (s1En) begin
        s1Valid <= io.inValid;
        if (io.inValid) s1q <= nxt;
      end
      if (s2En) begin
        s2Valid <= s1Valid;
        if (s1Valid) begin
          dq   <= d;
          boq  <= boN;
          ovfq <= ovfN;
          zq   <= zN;
        end
      end
    end
  end

  assign io.inReady   = s1En;
  assign io.outValid  = s2Valid;
  assign io.diff      = dq;
  assign io.borrowOut = boq;
  assign io.overflow  = ovfq;
  assign io.zero      = zq;

endmodule

// File: tb/tb_pipelined_csel_subtractor.sv
// Directed table, stall/reset sequences and a
// random valid/ready stream against a-b-bIn.
module tb_pipelined_csel_subtractor;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipelined_csel_subtractor_if #(.WIDTH(16)) bus ();

  pipelined_csel_subtractor #(
    .WIDTH (16),
    .BLOCK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ovf;
    logic        z;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ovf;
    logic        z;
  } res_t;

  vec_t vt[12];
  res_t exq[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t refsub(logic [15:0] a,
                                  logic [15:0] b,
                                  logic bin);
    res_t r;
    logic [16:0] w;
    w     = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    r.d   = w[15:0];
    r.bo  = w[16];
    r.ovf = (a[15] != b[15]) && (w[15] != a[15]);
    r.z   = (w[15:0] == 16'd0);
    return r;
  endfunction

  function automatic res_t curout();
    res_t r;
    r.d   = bus.diff;
    r.bo  = bus.borrowOut;
    r.ovf = bus.overflow;
    r.z   = bus.zero;
    return r;
  endfunction

  res_t held;
  res_t gotr;
  int   sent;
  int   recv;
  int   stall;
  bit   seen;
  bit   pend;
  int   cyc;

  initial begin
    vt[0]  = '{16'h0005, 16'h0003, 1'b0,
               16'h0002, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{16'h0000, 16'h0001, 1'b0,
               16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{16'h8000, 16'h0001, 1'b0,
               16'h7FFF, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{16'h7FFF, 16'hFFFF, 1'b0,
               16'h8000, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{16'h0100, 16'h00FF, 1'b1,
               16'h0000, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{16'h1234, 16'h1234, 1'b0,
               16'h0000, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{16'h0000, 16'h0000, 1'b1,
               16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{16'hFFFF, 16'hFFFF, 1'b1,
               16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{16'h00FF, 16'h0001, 1'b1,
               16'h00FD, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{16'h8000, 16'h7FFF, 1'b0,
               16'h0001, 1'b0, 1'b1, 1'b0};
    vt[10] = '{16'h0000, 16'h8000, 1'b0,
               16'h8000, 1'b1, 1'b1, 1'b0};
    vt[11] = '{16'hFFFF, 16'h0000, 1'b0,
               16'hFFFF, 1'b0, 1'b0, 1'b0};

    rst          = 1'b1;
    bus.inValid  = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.borrowIn = 1'b0;
    bus.outReady = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_outValid", 32'(bus.outValid), 0);
    chk("rst_diff", 32'(bus.diff), 0);
    chk("rst_borrow", 32'(bus.borrowOut), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_zero", 32'(bus.zero), 0);
    chk("rst_inReady", 32'(bus.inReady), 1);

    // Directed table, one op at a time.
    bus.outReady = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      bus.inValid  = 1'b1;
      bus.a        = vt[i].a;
      bus.b        = vt[i].b;
      bus.borrowIn = vt[i].bin;
      #1;
      chk($sformatf("v%0d_inReady", i),
          32'(bus.inReady), 1);
      tick();
      bus.inValid = 1'b0;
      #1;
      chk($sformatf("v%0d_early", i),
          32'(bus.outValid), 0);
      tick();
      chk($sformatf("v%0d_outValid", i),
          32'(bus.outValid), 1);
      chk($sformatf("v%0d_diff", i),
          32'(bus.diff), 32'(vt[i].d));
      chk($sformatf("v%0d_borrow", i),
          32'(bus.borrowOut), 32'(vt[i].bo));
      chk($sformatf("v%0d_ovf", i),
          32'(bus.overflow), 32'(vt[i].ovf));
      chk($sformatf("v%0d_zero", i),
          32'(bus.zero), 32'(vt[i].z));
    end
    tick();
    tick();
    chk("drain_outValid", 32'(bus.outValid), 0);

    // Five-op stream with a 4-cycle output stall.
    exq.delete();
    sent  = 0;
    recv  = 0;
    stall = 0;
    seen  = 1'b0;
    cyc   = 0;
    while (recv < 5 && cyc < 60) begin
      bus.inValid = (sent < 5);
      if (sent < 5) begin
        bus.a        = vt[sent].a;
        bus.b        = vt[sent].b;
        bus.borrowIn = vt[sent].bin;
      end
      #1;
      if (!seen && bus.outValid) begin
        seen  = 1'b1;
        stall = 4;
        held  = curout();
      end
      bus.outReady = (stall == 0);
      #1;
      if (stall > 0) begin
        chk("stall_outValid", 32'(bus.outValid), 1);
        chk("stall_hold", 32'(curout()),
            32'(held));
        chk("stall_inReady", 32'(bus.inReady), 0);
        stall--;
      end else if (seen) begin
        chk("nogap_outValid", 32'(bus.outValid), 1);
      end
      if (bus.outValid && bus.outReady) begin
        chk($sformatf("s%0d_res", recv),
            32'(curout()),
            32'(refsub(vt[recv].a, vt[recv].b,
                       vt[recv].bin)));
        recv++;
      end
      if (bus.inValid && bus.inReady) sent++;
      tick();
      cyc++;
    end
    chk("stream_count", recv, 5);
    bus.inValid = 1'b0;
    tick();

    // Reset with two ops in flight.
    bus.outReady = 1'b0;
    bus.inValid  = 1'b1;
    bus.a        = 16'h0000;
    bus.b        = 16'h0001;
    bus.borrowIn = 1'b0;
    tick();
    bus.a = 16'h1111;
    tick();
    #1;
    chk("pre_rst_outValid", 32'(bus.outValid), 1);
    rst          = 1'b1;
    bus.a        = 16'h4444;
    tick();
    rst         = 1'b0;
    bus.inValid = 1'b0;
    #1;
    chk("mid_rst_outValid", 32'(bus.outValid), 0);
    chk("mid_rst_outs", 32'(curout()), 0);
    chk("mid_rst_inReady", 32'(bus.inReady), 1);
    bus.outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale", 32'(bus.outValid), 0);
    end

    // Random valid/ready stream.
    exq.delete();
    sent = 0;
    recv = 0;
    pend = 1'b0;
    cyc  = 0;
    while (recv < 10000 && cyc < 60000) begin
      if (!pend && sent < 10000 &&
          ($urandom_range(3) != 0)) begin
        pend         = 1'b1;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.borrowIn = 1'($urandom);
      end
      bus.inValid  = pend;
      bus.outReady = ($urandom_range(3) != 0);
      #1;
      if (bus.outValid && bus.outReady) begin
        if (exq.size() == 0) begin
          chk("rnd_unexpected", 1, 0);
        end else begin
          gotr = exq.pop_front();
          chk("rnd_res", 32'(curout()), 32'(gotr));
        end
        recv++;
      end
      if (bus.inValid && bus.inReady) begin
        exq.push_back(refsub(bus.a, bus.b,
                             bus.borrowIn));
        sent++;
        pend = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("rnd_count", recv, 10000);
    chk("rnd_leftover", exq.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
